// File: rtl/savestate_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : savestate_pkg
//  Description : Shared types and info codes for the savestate request
//                handler: FSM state enum, slot type and OSD result codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package savestate_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    typedef logic [1:0] slot_t;

    localparam logic [7:0] INFO_LOAD_INVALID = 8'd17;
    localparam logic [7:0] INFO_SAVE_OK      = 8'd18;
    localparam logic [7:0] INFO_LOAD_OK      = 8'd19;
    localparam logic [7:0] INFO_SAVE_ERR     = 8'd20;
    localparam logic [7:0] INFO_LOAD_ERR     = 8'd21;
    localparam logic [7:0] INFO_TIMEOUT      = 8'd22;

endpackage
`default_nettype wire

// File: rtl/ss_info_merge.sv
`default_nettype none
// ============================================================================
//  Module      : ss_info_merge
//  Description : Merges handler-generated info codes with UI info strobes onto
//                a single registered OSD channel. Internal codes win; a UI
//                strobe that collides is parked in a 1-entry hold buffer and
//                sent on the next free cycle. A newer UI strobe replaces the
//                parked one.
//  Ports       : clk, reset       - clock, async active-high reset
//                i_int_req/code   - internal info strobe + code
//                i_ui_req/code    - UI info strobe + code
//                o_req/o_code     - merged OSD strobe + code (registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module ss_info_merge (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_int_req,
    input  logic [7:0] i_int_code,
    input  logic       i_ui_req,
    input  logic [7:0] i_ui_code,
    output logic       o_req,
    output logic [7:0] o_code
);

    logic       req_q,      req_d;
    logic [7:0] code_q,     code_d;
    logic       hold_vld_q, hold_vld_d;
    logic [7:0] hold_q,     hold_d;

    always_comb begin
        req_d      = 1'b0;
        code_d     = 8'd0;
        hold_vld_d = hold_vld_q;
        hold_d     = hold_q;
        if (i_int_req) begin
            req_d  = 1'b1;
            code_d = i_int_code;
            if (i_ui_req) begin
                hold_vld_d = 1'b1;
                hold_d     = i_ui_code;
            end
        end else if (i_ui_req) begin
            // A fresh UI code supersedes anything still parked.
            req_d      = 1'b1;
            code_d     = i_ui_code;
            hold_vld_d = 1'b0;
        end else if (hold_vld_q) begin
            req_d      = 1'b1;
            code_d     = hold_q;
            hold_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q      <= 1'b0;
            code_q     <= 8'd0;
            hold_vld_q <= 1'b0;
            hold_q     <= 8'd0;
        end else begin
            req_q      <= req_d;
            code_q     <= code_d;
            hold_vld_q <= hold_vld_d;
            hold_q     <= hold_d;
        end
    end

    assign o_req  = req_q;
    assign o_code = code_q;

endmodule
`default_nettype wire

// File: rtl/savestate_request_handler.sv
`default_nettype none
// ============================================================================
//  Module      : savestate_request_handler
//  Description : Accepts slot save/load pulses from the savestate UI, runs a
//                req/done handshake with the savestate engine (with watchdog),
//                maintains the per-slot valid bitmap and reports results on
//                the OSD info channel.
//  Ports       : clk, reset              - clock, async active-high reset
//                ss_save/ss_load/slot    - UI requests
//                ui_info_req/ui_info     - UI info strobe to forward
//                init_valid/_we          - bitmap load from header scan
//                eng_save/eng_load       - 1-cycle engine start pulses
//                eng_addr                - slot base address, held while busy
//                eng_done/eng_error      - engine completion
//                valid_states            - per-slot valid bitmap
//                busy                    - operation in flight
//                osd_info_req/osd_info   - merged OSD info channel
//  Revision    : 1.0 - initial release
// ============================================================================
module savestate_request_handler
    import savestate_pkg::*;
#(
    parameter int                ADDR_W       = 27,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = ADDR_W'('h3C00000),
    parameter int                SLOT_SIZE    = 'h0100000,
    parameter int                TIMEOUT_BITS = 26
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ss_save,
    input  logic              ss_load,
    input  logic [1:0]        slot,
    input  logic              ui_info_req,
    input  logic [7:0]        ui_info,
    input  logic [3:0]        init_valid,
    input  logic              init_valid_we,
    output logic              eng_save,
    output logic              eng_load,
    output logic [ADDR_W-1:0] eng_addr,
    input  logic              eng_done,
    input  logic              eng_error,
    output logic [3:0]        valid_states,
    output logic              busy,
    output logic              osd_info_req,
    output logic [7:0]        osd_info
);

    localparam int SLOT_SHIFT = $clog2(SLOT_SIZE);

    state_t                  state_q, state_d;
    logic                    is_save_q, is_save_d;
    slot_t                   slot_q, slot_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [3:0]              valid_q, valid_d;
    logic [TIMEOUT_BITS-1:0] wd_q, wd_d;
    logic                    int_req;
    logic [7:0]              int_code;
    logic [ADDR_W-1:0]       slot_addr;

    // Power-of-two slots: the slot index simply lands above the offset bits.
    assign slot_addr = BASE_ADDR + (ADDR_W'(slot) << SLOT_SHIFT);

    always_comb begin
        state_d   = state_q;
        is_save_d = is_save_q;
        slot_d    = slot_q;
        addr_d    = addr_q;
        valid_d   = init_valid_we ? init_valid : valid_q;
        wd_d      = '0;
        int_req   = 1'b0;
        int_code  = 8'd0;
        eng_save  = 1'b0;
        eng_load  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Save has priority; a simultaneous load is dropped silently.
                if (ss_save || (ss_load && valid_q[slot])) begin
                    state_d   = ST_ISSUE;
                    is_save_d = ss_save;
                    slot_d    = slot;
                    addr_d    = slot_addr;
                end else if (ss_load) begin
                    int_req  = 1'b1;
                    int_code = INFO_LOAD_INVALID;
                end
            end
            ST_ISSUE: begin
                eng_save = is_save_q;
                eng_load = ~is_save_q;
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                wd_d = wd_q + 1'b1;
                if (eng_done) begin
                    state_d = ST_IDLE;
                    int_req = 1'b1;
                    if (eng_error) begin
                        int_code = is_save_q ? INFO_SAVE_ERR : INFO_LOAD_ERR;
                        if (is_save_q) valid_d[slot_q] = 1'b0;
                    end else begin
                        int_code = is_save_q ? INFO_SAVE_OK : INFO_LOAD_OK;
                        if (is_save_q) valid_d[slot_q] = 1'b1;
                    end
                end else if (wd_q[TIMEOUT_BITS-1]) begin
                    state_d  = ST_IDLE;
                    int_req  = 1'b1;
                    int_code = INFO_TIMEOUT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            is_save_q <= 1'b0;
            slot_q    <= '0;
            addr_q    <= '0;
            valid_q   <= 4'd0;
            wd_q      <= '0;
        end else begin
            state_q   <= state_d;
            is_save_q <= is_save_d;
            slot_q    <= slot_d;
            addr_q    <= addr_d;
            valid_q   <= valid_d;
            wd_q      <= wd_d;
        end
    end

    assign eng_addr     = addr_q;
    assign valid_states = valid_q;
    assign busy         = (state_q != ST_IDLE);

    ss_info_merge u_info_merge (
        .clk        (clk),
        .reset      (reset),
        .i_int_req  (int_req),
        .i_int_code (int_code),
        .i_ui_req   (ui_info_req),
        .i_ui_code  (ui_info),
        .o_req      (osd_info_req),
        .o_code     (osd_info)
    );

endmodule
`default_nettype wire
